// File: rtl/nonce_tracker_pkg.sv
// Shared types and helpers for the nonce tracker: the round tag carried through
// the hash-pipeline delay line and the processor index range check.
package nonce_pkg;

  localparam int NONCE_WIDTH_DEFAULT = 32;
  localparam int EPOCH_WIDTH_DEFAULT = 2;

  // Default-width tag; the tracker builds the same layout for its own widths.
  typedef struct packed {
    logic                           valid;
    logic [EPOCH_WIDTH_DEFAULT-1:0] epoch;
    logic [NONCE_WIDTH_DEFAULT-1:0] base;
  } round_tag_t;

  function automatic logic index_in_range(input logic [31:0] index,
                                          input logic [31:0] num_processors);
    return index < num_processors;
  endfunction

endpackage

// File: rtl/round_delay_line.sv
// Fixed-latency shift register that carries each round's tag alongside the
// hash pipeline, so the tag emerges exactly when that round's result arrives.
module round_delay_line #(
  parameter int  DEPTH = 4,
  parameter type tag_t = nonce_pkg::round_tag_t
) (
  input  logic clk,
  input  logic rst,
  input  tag_t head,
  output tag_t tail
);

  tag_t stage [DEPTH];

  // NOTE: only the valid bits matter after reset, but clearing whole entries keeps
  // every stage under one async reset instead of mixing reset and non-reset flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= head;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail = stage[DEPTH-1];

endmodule

// File: rtl/nonce_tracker.sv
// Nonce bookkeeping between round issuer and result collector: tags rounds with
// base nonce and block epoch, rebuilds winning nonces and holds them for the consumer.
module nonce_tracker
  import nonce_pkg::*;
#(
  parameter int NUMPROCESSORS = 10,
  parameter int INDEXWIDTH    = 10,
  parameter int NONCEWIDTH    = 32,
  parameter int PIPEDEPTH     = 4,
  parameter int EPOCHWIDTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  newblock_i,
  output logic [NONCEWIDTH-1:0] base_nonce_o,
  input  logic                  success_i,
  input  logic [INDEXWIDTH-1:0] processor_index_i,
  output logic                  found_valid_o,
  output logic [NONCEWIDTH-1:0] nonce_o,
  input  logic                  ready_i,
  output logic                  drop_o,
  output logic                  exhausted_o
);

  localparam int SUMWIDTH = ((NONCEWIDTH > INDEXWIDTH) ? NONCEWIDTH : INDEXWIDTH) + 1;
  localparam logic [NONCEWIDTH-1:0] STEP      = NONCEWIDTH'(NUMPROCESSORS);
  localparam logic [EPOCHWIDTH-1:0] EPOCH_ONE = EPOCHWIDTH'(1);

  typedef struct packed {
    logic                  valid;
    logic [EPOCHWIDTH-1:0] epoch;
    logic [NONCEWIDTH-1:0] base;
  } tag_t;

  logic [NONCEWIDTH-1:0] base_q;
  logic [EPOCHWIDTH-1:0] epoch_q;
  logic                  exhausted_q;
  logic                  found_q;
  logic                  drop_q;
  logic [NONCEWIDTH-1:0] nonce_q;

  logic                  newblock_issue;
  logic                  round_issue;
  logic                  pop;
  logic                  accept;
  logic [NONCEWIDTH:0]   base_next;
  logic [SUMWIDTH-1:0]   hit_sum;
  tag_t                  head;
  tag_t                  tail;

  assign newblock_issue = valid_i & newblock_i;
  assign round_issue    = valid_i & ~newblock_i & ~exhausted_q;
  assign base_nonce_o   = newblock_issue ? '0 : base_q;
  assign base_next      = {1'b0, base_q} + {1'b0, STEP};
  assign pop            = ready_i & found_q;

  // NOTE: every variable written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    head       = '0;
    head.valid = newblock_issue | round_issue;
    head.epoch = newblock_issue ? epoch_q + EPOCH_ONE : epoch_q;
    head.base  = base_nonce_o;
  end

  round_delay_line #(
    .DEPTH (PIPEDEPTH),
    .tag_t (tag_t)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .head (head),
    .tail (tail)
  );

  // The sum is wide enough for either operand, so any bit above NONCEWIDTH means a wrap.
  assign hit_sum = SUMWIDTH'(tail.base) + SUMWIDTH'(processor_index_i);
  assign accept  = tail.valid && (tail.epoch == epoch_q) && !newblock_issue && success_i
                && index_in_range(32'(processor_index_i), NUMPROCESSORS)
                && (hit_sum[SUMWIDTH-1:NONCEWIDTH] == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q      <= '0;
      epoch_q     <= '0;
      exhausted_q <= 1'b0;
    end else if (newblock_issue) begin
      base_q      <= STEP;
      epoch_q     <= epoch_q + EPOCH_ONE;
      exhausted_q <= 1'b0;
    end else if (round_issue) begin
      if (base_next[NONCEWIDTH]) exhausted_q <= 1'b1;
      else                       base_q      <= base_next[NONCEWIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      found_q <= 1'b0;
      nonce_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (newblock_issue) begin
        found_q <= 1'b0;
      end else if (accept) begin
        if (!found_q || pop) begin
          found_q <= 1'b1;
          nonce_q <= hit_sum[NONCEWIDTH-1:0];
        end else begin
          drop_q <= 1'b1;
        end
      end else if (pop) begin
        found_q <= 1'b0;
      end
    end
  end

  assign found_valid_o = found_q;
  assign nonce_o       = nonce_q;
  assign drop_o        = drop_q;
  assign exhausted_o   = exhausted_q;

endmodule

// File: tb/tb_nonce_tracker.sv
// Directed bench for nonce_tracker: a default-width instance and an 8-bit nonce
// instance for exhaustion; winning nonces are checked through scoreboard queues.
module tb_nonce_tracker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_valid, a_newblock, a_success, a_ready;
  logic [9:0]  a_index;
  logic [31:0] a_base, a_nonce;
  logic        a_found, a_drop, a_exh;

  logic        b_valid, b_newblock, b_success, b_ready;
  logic [9:0]  b_index;
  logic [7:0]  b_base, b_nonce;
  logic        b_found, b_drop, b_exh;

  nonce_tracker u_dut_a (
    .clk (clk), .rst (rst), .valid_i (a_valid), .newblock_i (a_newblock),
    .base_nonce_o (a_base), .success_i (a_success), .processor_index_i (a_index),
    .found_valid_o (a_found), .nonce_o (a_nonce), .ready_i (a_ready),
    .drop_o (a_drop), .exhausted_o (a_exh)
  );

  nonce_tracker #(.NONCEWIDTH(8)) u_dut_b (
    .clk (clk), .rst (rst), .valid_i (b_valid), .newblock_i (b_newblock),
    .base_nonce_o (b_base), .success_i (b_success), .processor_index_i (b_index),
    .found_valid_o (b_found), .nonce_o (b_nonce), .ready_i (b_ready),
    .drop_o (b_drop), .exhausted_o (b_exh)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_a [$];
  logic [7:0]  exp_b [$];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic nb, input logic s,
                         input logic [9:0] idx, input logic rdy);
    a_valid = v; a_newblock = nb; a_success = s; a_index = idx; a_ready = rdy;
  endtask

  task automatic b_drive(input logic v, input logic nb, input logic s, input logic [9:0] idx);
    b_valid = v; b_newblock = nb; b_success = s; b_index = idx;
  endtask

  // Newblock then rounds at bases 10..250; the 250 round sets exhausted_o.
  task automatic b_exhaust();
    b_drive(1, 1, 0, 0); #1; check("b_newblock_base", b_base, 0);
    step(); check("b_newblock_clears_exh", b_exh, 0);
    for (int k = 1; k <= 25; k++) begin
      b_drive(1, 0, 0, 0); #1; check("b_round_base", b_base, 64'(k * 10));
      step(); check("b_exhausted_flag", b_exh, 64'(k == 25));
    end
    b_drive(0, 0, 0, 0);
  endtask

  // Monitors: a nonce is newly presented when found rises or reloads right after a pop.
  initial begin : mon_a
    logic prev_found, prev_pop;
    logic [31:0] exp;
    prev_found = 1'b0; prev_pop = 1'b0;
    forever begin
      @(negedge clk);
      if (a_found && (!prev_found || prev_pop)) begin
        if (exp_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_unexpected_nonce: got %0d, expected none", a_nonce);
        end else begin
          exp = exp_a.pop_front();
          check("a_scoreboard_nonce", a_nonce, exp);
        end
      end
      prev_found = a_found;
      prev_pop   = a_found & a_ready;
    end
  end

  initial begin : mon_b
    logic prev_found, prev_pop;
    logic [7:0] exp;
    prev_found = 1'b0; prev_pop = 1'b0;
    forever begin
      @(negedge clk);
      if (b_found && (!prev_found || prev_pop)) begin
        if (exp_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected_nonce: got %0d, expected none", b_nonce);
        end else begin
          exp = exp_b.pop_front();
          check("b_scoreboard_nonce", b_nonce, exp);
        end
      end
      prev_found = b_found;
      prev_pop   = b_found & b_ready;
    end
  end

  initial begin
    rst = 1'b0;
    a_drive(0, 0, 0, 0, 0);
    b_drive(0, 0, 0, 0);
    b_ready = 1'b1;
    step(); step();
    check("reset_found", a_found, 0);
    check("reset_nonce", a_nonce, 0);
    check("reset_drop", a_drop, 0);
    check("reset_exhausted", a_exh, 0);
    check("reset_base", a_base, 0);
    rst = 1'b1;

    // Basic: newblock, two rounds, index 3 on the base-20 round
    a_drive(1, 1, 0, 0, 0); #1; check("basic_base0", a_base, 0);  step();
    a_drive(1, 0, 0, 0, 0); #1; check("basic_base1", a_base, 10); step();
    a_drive(1, 0, 0, 0, 0); #1; check("basic_base2", a_base, 20); step();
    a_drive(0, 0, 0, 0, 0);
    repeat (3) step();
    a_drive(0, 0, 1, 3, 0); exp_a.push_back(32'd23); step();
    check("basic_found", a_found, 1);
    check("basic_nonce", a_nonce, 23);
    a_drive(0, 0, 0, 0, 1); step();
    check("basic_pop_clears", a_found, 0);

    // Stale: base-30 round superseded by a newblock before its result
    a_drive(1, 0, 0, 0, 0); #1; check("stale_round_base", a_base, 30); step();
    a_drive(0, 0, 0, 0, 0); step();
    a_drive(1, 1, 0, 0, 0); #1; check("stale_newblock_base", a_base, 0); step();
    a_drive(0, 0, 0, 0, 0); step();
    a_drive(0, 0, 1, 1, 0); step();
    check("stale_no_found", a_found, 0);
    check("stale_no_drop", a_drop, 0);

    // Same-cycle newblock discards the hit and flushes the held nonce
    a_drive(1, 0, 0, 0, 0); #1; check("same_round_base", a_base, 10); step();
    a_drive(1, 0, 0, 0, 0); step();
    a_drive(0, 0, 0, 0, 0); step(); step();
    a_drive(0, 0, 1, 2, 0); exp_a.push_back(32'd12); step();
    check("same_held_nonce", a_nonce, 12);
    a_drive(1, 1, 1, 4, 0); step();
    check("same_flushed", a_found, 0);
    check("same_no_drop", a_drop, 0);
    a_drive(0, 0, 0, 0, 0);
    repeat (4) step();

    // Backpressure: held 3, 17 dropped, then pop-and-load 21 on the same edge
    a_drive(1, 1, 0, 0, 0); step();
    a_drive(1, 0, 0, 0, 0); #1; check("bp_round_base", a_base, 10); step();
    a_drive(1, 0, 0, 0, 0); step();
    a_drive(0, 0, 0, 0, 0); step();
    a_drive(0, 0, 1, 3, 0); exp_a.push_back(32'd3); step();
    check("bp_first_nonce", a_nonce, 3);
    a_drive(0, 0, 1, 7, 0); step();
    check("bp_drop_pulse", a_drop, 1);
    check("bp_held_nonce", a_nonce, 3);
    check("bp_held_found", a_found, 1);
    a_drive(0, 0, 1, 1, 1); exp_a.push_back(32'd21); step();
    check("bp_pop_load_found", a_found, 1);
    check("bp_pop_load_nonce", a_nonce, 21);
    check("bp_drop_one_cycle", a_drop, 0);
    a_drive(0, 0, 0, 0, 1); step();
    check("bp_pop_clears", a_found, 0);
    check("bp_pop_keeps_nonce", a_nonce, 21);
    a_drive(0, 0, 0, 0, 0);

    // Exhaustion on the 8-bit instance: index 6 on base 250 wraps and is dropped silently
    b_exhaust();
    b_drive(1, 0, 0, 0); #1; check("b_base_holds", b_base, 250); step();
    check("b_still_exhausted", b_exh, 1);
    b_drive(0, 0, 0, 0); step(); step();
    b_drive(0, 0, 1, 6); step();
    check("b_wrap_no_found", b_found, 0);
    check("b_wrap_no_drop", b_drop, 0);
    b_drive(0, 0, 1, 0); step();
    check("b_exhausted_round_no_hit", b_found, 0);
    b_drive(0, 0, 0, 0);

    b_exhaust();
    step(); step(); step();
    b_drive(0, 0, 1, 5); exp_b.push_back(8'd255); step();
    check("b_top_found", b_found, 1);
    check("b_top_nonce", b_nonce, 255);
    b_drive(0, 0, 0, 0); step();
    check("b_top_popped", b_found, 0);
    b_exhaust();

    // Bad index, then reset with a nonce held and rounds in flight
    a_drive(1, 0, 0, 0, 0); #1; check("bad_round_base", a_base, 30); step();
    a_drive(1, 0, 0, 0, 0); step();
    a_drive(0, 0, 0, 0, 0); step(); step();
    a_drive(0, 0, 1, 10, 0); step();
    check("bad_index_ignored", a_found, 0);
    check("bad_index_no_drop", a_drop, 0);
    a_drive(0, 0, 1, 9, 0); exp_a.push_back(32'd49); step();
    check("max_index_nonce", a_nonce, 49);
    a_drive(1, 0, 0, 0, 0); step();
    a_drive(1, 0, 0, 0, 0); step();
    a_drive(0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("rst_found_now", a_found, 0);
    check("rst_nonce_now", a_nonce, 0);
    check("rst_exh_now", b_exh, 0);
    check("rst_base_now", b_base, 0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_drive(0, 0, 1, 0, 0); step();
      check("rst_prior_round_no_hit", a_found, 0);
    end
    a_drive(0, 0, 0, 0, 0);
    step(); step();

    check("a_queue_drained", exp_a.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
